// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and helpers for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int WORD_BYTES = 4;
  localparam int WCOUNT_W = 16;
  function automatic logic [29:0] word_index(input logic [31:0] adr);
    return adr[31:2];
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 RAM with synchronous write and combinational read
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] ridx,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[widx] <= wdata;
  assign rdata = mem[ridx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with fixed latency, error flags and a write log
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                memread,
  input  logic                memwrite,
  input  logic [31:0]         dataadr,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                ready,
  output logic                err,
  output logic [WCOUNT_W-1:0] wr_count,
  output logic [31:0]         last_wr_adr,
  output logic [31:0]         last_wr_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY > 0 ? LATENCY - 1 : 0);
  state_t st;
  logic [2:0] cnt;
  logic wr_q, cf_q, idle, rq_wr, rq_cf, rq_bad, go_resp, we;
  logic [31:0] adr_q, wd_q, rq_adr, rdata;
  logic [AW-1:0] ridx, widx;
  // In IDLE the live bus is used so a zero-latency access can respond next cycle
  always_comb begin
    idle = st == IDLE;
    rq_adr = idle ? dataadr : adr_q;
    rq_wr = idle ? memwrite : wr_q;
    rq_cf = idle ? memread & memwrite : cf_q;
    rq_bad = rq_cf | (|rq_adr[1:0]) | (rq_adr >= 32'(WORD_BYTES * DEPTH));
    ridx = AW'(word_index(rq_adr));
    widx = AW'(word_index(adr_q));
    go_resp = idle ? (memread | memwrite) && LATENCY == 0 : st == WAIT && cnt == 3'd0;
    we = st == RESP && wr_q && !err;
  end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk), .we(we), .widx(widx), .wdata(wd_q), .ridx(ridx), .rdata(rdata)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      cnt <= '0;
      ready <= 1'b0;
      err <= 1'b0;
      readdata <= '0;
      wr_count <= '0;
      last_wr_adr <= '0;
      last_wr_data <= '0;
      adr_q <= '0;
      wd_q <= '0;
      wr_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      ready <= go_resp;
      err <= go_resp && rq_bad;
      readdata <= (go_resp && !rq_bad && !rq_wr) ? rdata : '0;
      if (we) begin
        last_wr_adr <= adr_q;
        last_wr_data <= wd_q;
        wr_count <= (wr_count == '1) ? wr_count : wr_count + 1'b1;
      end
      if (idle && (memread | memwrite)) begin
        adr_q <= dataadr;
        wd_q <= writedata;
        wr_q <= memwrite;
        cf_q <= memread & memwrite;
        cnt <= CNT_INIT;
        st <= (LATENCY == 0) ? RESP : WAIT;
      end else if (st == WAIT) begin
        cnt <= (cnt == 3'd0) ? cnt : cnt - 3'd1;
        st <= (cnt == 3'd0) ? RESP : WAIT;
      end else if (st == RESP) begin
        st <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven, directed and randomized checks against a word-array model
module tb_dmem_responder;
  localparam int LAT = 2;
  logic clk, reset;
  logic memread, memwrite, ready, err;
  logic [31:0] dataadr, writedata, readdata, last_wr_adr, last_wr_data;
  logic [15:0] wr_count;
  logic rd1, wr1, ready1, err1;
  logic [31:0] adr1, wd1, readdata1, la1, ld1;
  logic [15:0] cnt1;
  int total = 0, bad = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(LAT)) u0 (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .readdata(readdata), .ready(ready),
    .err(err), .wr_count(wr_count), .last_wr_adr(last_wr_adr), .last_wr_data(last_wr_data)
  );
  dmem_responder #(.DEPTH(64), .LATENCY(0)) u1 (
    .clk(clk), .reset(reset), .memread(rd1), .memwrite(wr1),
    .dataadr(adr1), .writedata(wd1), .readdata(readdata1), .ready(ready1),
    .err(err1), .wr_count(cnt1), .last_wr_adr(la1), .last_wr_data(ld1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mm [64];
  bit mv [64];
  int unsigned m_cnt;
  logic [31:0] m_la, m_ld;

  function automatic bit exp_err(input bit rd, input bit wr, input logic [31:0] adr);
    return (rd && wr) || (adr % 4 != 0) || (adr / 4 >= 64);
  endfunction

  function automatic void model_apply(input bit rd, input bit wr, input logic [31:0] adr, input logic [31:0] wd);
    if (wr && !exp_err(rd, wr, adr)) begin
      mm[adr / 4] = wd;
      mv[adr / 4] = 1'b1;
      m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
      m_la = adr;
      m_ld = wd;
    end
  endfunction

  function automatic void model_reset();
    m_cnt = 0;
    m_la = '0;
    m_ld = '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic chk_log(input string name);
    chk({name, " wr_count"}, 32'(wr_count), m_cnt);
    chk({name, " last_wr_adr"}, last_wr_adr, m_la);
    chk({name, " last_wr_data"}, last_wr_data, m_ld);
  endtask

  // Starts at a negedge in IDLE; ends at the negedge after the ready pulse.
  task automatic access(input bit rd, input bit wr, input logic [31:0] adr, input logic [31:0] wd,
                        input bit junk, output int lat, output logic g_err, output logic [31:0] g_rd);
    memread = rd; memwrite = wr; dataadr = adr; writedata = wd;
    lat = 99; g_err = 1'bx; g_rd = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready) begin
        lat = n; g_err = err; g_rd = readdata;
        memread = 0; memwrite = 0;
        break;
      end
      memread = junk ? 1'($urandom) : 1'b0;
      memwrite = junk ? 1'($urandom) : 1'b0;
      dataadr = $urandom; writedata = $urandom;
    end
    memread = 0; memwrite = 0;
    @(negedge clk);
    chk("pulse width", 32'(ready), 0);
    model_apply(rd, wr, adr, wd);
  endtask

  typedef struct {
    bit rd; bit wr; logic [31:0] adr; logic [31:0] wd;
    bit e; logic [31:0] rdata; logic [15:0] cnt;
  } vec_t;
  vec_t tbl [20];

  int lat;
  logic g_err;
  logic [31:0] g_rd;

  initial begin
    tbl[0]  = '{0, 1, 32,   3,      0, 0,      1};
    tbl[1]  = '{0, 1, 28,   6,      0, 0,      2};
    tbl[2]  = '{0, 1, 24,   9,      0, 0,      3};
    tbl[3]  = '{0, 1, 20,   28,     0, 0,      4};
    tbl[4]  = '{1, 0, 32,   0,      0, 3,      4};
    tbl[5]  = '{1, 0, 28,   0,      0, 6,      4};
    tbl[6]  = '{1, 0, 24,   0,      0, 9,      4};
    tbl[7]  = '{1, 0, 20,   0,      0, 28,     4};
    tbl[8]  = '{0, 1, 84,   'h77,   0, 0,      5};
    tbl[9]  = '{0, 1, 86,   7,      1, 0,      5};
    tbl[10] = '{0, 1, 256,  7,      1, 0,      5};
    tbl[11] = '{1, 0, 84,   0,      0, 'h77,   5};
    tbl[12] = '{0, 1, 40,   'hAA,   0, 0,      6};
    tbl[13] = '{1, 1, 40,   5,      1, 0,      6};
    tbl[14] = '{1, 0, 40,   0,      0, 'hAA,   6};
    tbl[15] = '{1, 0, 52,   0,      0, 1,      6};
    tbl[16] = '{0, 1, 252,  'h1234, 0, 0,      7};
    tbl[17] = '{1, 0, 252,  0,      0, 'h1234, 7};
    tbl[18] = '{1, 0, 254,  0,      1, 0,      7};
    tbl[19] = '{1, 0, 1024, 0,      1, 0,      7};
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    model_reset();
    reset = 0; memread = 0; memwrite = 0; dataadr = 0; writedata = 0;
    rd1 = 0; wr1 = 0; adr1 = 0; wd1 = 0;
    #10;
    chk("reset ready", 32'(ready), 0);
    chk("reset err", 32'(err), 0);
    chk("reset readdata", readdata, 0);
    chk_log("reset");
    #12 reset = 1;
    @(negedge clk);

    access(0, 1, 52, 1, 0, lat, g_err, g_rd);
    chk("first store latency", lat, LAT + 1);
    chk("first store err", 32'(g_err), 0);
    chk("first store wr_count", 32'(wr_count), 1);
    chk("first store last_wr_adr", last_wr_adr, 52);
    chk("first store last_wr_data", last_wr_data, 1);

    reset = 0;
    @(negedge clk);
    chk("mid reset wr_count", 32'(wr_count), 0);
    reset = 1;
    model_reset();
    @(negedge clk);

    foreach (tbl[i]) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wd, 1, lat, g_err, g_rd);
      chk($sformatf("tbl%0d latency", i), lat, LAT + 1);
      chk($sformatf("tbl%0d err", i), 32'(g_err), 32'(tbl[i].e));
      if (tbl[i].rd || tbl[i].e) chk($sformatf("tbl%0d readdata", i), g_rd, tbl[i].rdata);
      chk($sformatf("tbl%0d wr_count", i), 32'(wr_count), 32'(tbl[i].cnt));
      chk_log($sformatf("tbl%0d", i));
    end

    access(0, 1, 60, 9, 0, lat, g_err, g_rd);
    chk("dropped store latency", lat, LAT + 1);
    chk("dropped store err", 32'(g_err), 0);
    chk("dropped store wr_count", 32'(wr_count), 8);
    chk("dropped store last_wr_adr", last_wr_adr, 60);
    chk("dropped store last_wr_data", last_wr_data, 9);
    access(1, 0, 60, 0, 0, lat, g_err, g_rd);
    chk("dropped store readback", g_rd, 9);

    memwrite = 1; dataadr = 60; writedata = 'hDEAD;
    @(negedge clk);
    memwrite = 0;
    reset = 0;
    #1;
    chk("abort ready", 32'(ready), 0);
    chk("abort err", 32'(err), 0);
    chk("abort readdata", readdata, 0);
    chk("abort wr_count", 32'(wr_count), 0);
    chk("abort last_wr_adr", last_wr_adr, 0);
    chk("abort last_wr_data", last_wr_data, 0);
    model_reset();
    @(negedge clk);
    chk("abort ready in reset", 32'(ready), 0);
    reset = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort no late ready", 32'(ready), 0);
    end
    access(1, 0, 60, 0, 0, lat, g_err, g_rd);
    chk("post-abort latency", lat, LAT + 1);
    chk("post-abort readback", g_rd, 9);
    chk_log("post-abort");

    for (int i = 0; i < 80; i++) begin
      int op, sel;
      bit rd, wr, e;
      logic [31:0] adr, wd;
      op = $urandom_range(0, 9);
      sel = $urandom_range(0, 9);
      rd = (op < 4) || op >= 8;
      wr = op >= 4 && op <= 8;
      adr = 32'($urandom_range(0, 15)) * 4;
      if (sel == 8) adr = adr + 32'($urandom_range(1, 3));
      if (sel == 9) adr = (64 + 32'($urandom_range(0, 1000))) * 4;
      wd = $urandom;
      e = exp_err(rd, wr, adr);
      if (!e && rd && !wr && mv[adr / 4]) begin
        logic [31:0] expd;
        expd = mm[adr / 4];
        access(rd, wr, adr, wd, 1, lat, g_err, g_rd);
        chk($sformatf("rnd%0d readdata", i), g_rd, expd);
      end else begin
        access(rd, wr, adr, wd, 1, lat, g_err, g_rd);
        if (e) chk($sformatf("rnd%0d readdata", i), g_rd, 0);
      end
      chk($sformatf("rnd%0d latency", i), lat, LAT + 1);
      chk($sformatf("rnd%0d err", i), 32'(g_err), 32'(e));
      chk_log($sformatf("rnd%0d", i));
    end

    wr1 = 1; adr1 = 52; wd1 = 1;
    @(negedge clk);
    chk("lat0 store ready", 32'(ready1), 1);
    chk("lat0 store err", 32'(err1), 0);
    wr1 = 0;
    @(negedge clk);
    chk("lat0 wr_count", 32'(cnt1), 1);
    rd1 = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("lat0 ready k%0d", k), 32'(ready1), 32'(k % 2));
      chk($sformatf("lat0 readdata k%0d", k), readdata1, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("lat0 err k%0d", k), 32'(err1), 0);
    end
    rd1 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the processor's load/store interface (memread/memwrite, dataadr, writedata, readdata).
- Completes each access after a configurable latency and signals completion with a one-cycle ready pulse.
- Flags misaligned, out-of-range and conflicting accesses.
- Keeps a write log (last write address/data and a write count) that benches check instead of snooping the bus.

Parameters:
- DEPTH, 64, number of 32-bit words; valid byte addresses are 0 to 4*DEPTH-4.
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..7.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- memread  in  1  load request.
- memwrite  in  1  store request.
- dataadr  in  32  byte address.
- writedata  in  32  store data.
- readdata  out  32  load data; valid only while ready=1, otherwise 0.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag for the access; valid only with ready, otherwise 0.
- wr_count  out  16  number of successful stores; saturates at 16'hFFFF.
- last_wr_adr  out  32  byte address of the most recent successful store.
- last_wr_data  out  32  data of the most recent successful store.

Behaviour:
- Reset is asynchronous and active-low. While reset=0:
  - FSM goes to IDLE.
  - readdata, ready, err, wr_count, last_wr_adr and last_wr_data are all 0.
  - The latency counter is 0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If memread|memwrite is high at a rising edge, the request is accepted.
  - The captured request is: op (write if memwrite=1), dataadr, writedata.
  - Next state is WAIT with count=LATENCY-1 if LATENCY>0; otherwise RESP.
- WAIT:
  - Count decrements each cycle; at count==0 the next state is RESP.
  - The live request inputs are ignored; only the captured copy is used.
  - Withdrawing or changing the request mid-WAIT has no effect.
- RESP:
  - ready=1 for exactly this cycle; next state is always IDLE.
  - Accept-to-ready latency is LATENCY+1 cycles.
  - A request held high in the IDLE cycle that follows RESP is accepted as a new access.
  - Back-to-back accesses are therefore spaced LATENCY+2 cycles apart.
- Error conditions, evaluated on the captured request:
  - misaligned: adr[1:0]!=0.
  - out of range: adr[31:2]>=DEPTH.
  - conflict: memread and memwrite both high at acceptance.
- Store with no error:
  - The array word adr[31:2] is written at the rising edge that ends the RESP cycle.
  - last_wr_adr and last_wr_data are updated at that same edge.
  - wr_count increments at that same edge, saturating at 16'hFFFF.
- Load with no error: readdata = array[adr[31:2]] during RESP; err=0.
- Any error:
  - err=1 during RESP; readdata=0.
  - There is no array write and no log or count update.
  - A conflict is reported as err even if the address is valid; the array is not written.
- A load from a word never written returns X from the array. Benches initialise the array or only read written words.
- Reset asserted during WAIT or RESP:
  - The access is abandoned: no write, no ready pulse.
  - After release the FSM is in IDLE.
- An access with the same address as the immediately preceding store reads the new data; the write has already committed at the prior RESP edge.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - WORD_BYTES=4;
  - WCOUNT_W=16;
  - function word_index(adr) returning adr[31:2].
- One sub-module, dmem_array: synchronous-write / combinational-read RAM of DEPTH x 32, with ports clk, we, widx, wdata, ridx, rdata, and no reset.
- dmem_responder contains the FSM, latency counter, error check and write log.

Test Plan:
- Reset low for 22 ns, then high; store 1 to byte address 52 (LATENCY=2). Required: ready exactly 3 cycles after acceptance; err=0; wr_count=1; last_wr_adr=52; last_wr_data=1.
- Stores 3→32, 6→28, 9→24, 28→20, then loads of each address. Required: readdata 3, 6, 9, 28 respectively during each ready pulse; wr_count=4.
- Store 7 to address 86 (misaligned), then store 7 to address 256 (out of range with DEPTH=64). Required: each gives ready with err=1; wr_count unchanged; load of address 84 still returns its prior value.
- memread=memwrite=1 at address 40 with writedata=5. Required: err=1 with ready; no write; a following load of 40 returns the old value.
- Store 9 to address 60; drop memwrite during WAIT. Required: ready still pulses at cycle LATENCY+1 and the write commits. Repeat with reset driven low during WAIT. Required: no ready, no write, all outputs 0, FSM in IDLE.
- LATENCY=0 build with memread held high continuously on address 52. Required: ready pulses every 2 cycles with readdata=1.
